// File: rtl/trena_pkg.sv
// trena_pkg: shared definitions for the ultrasonic tape-measure control unit.
//   - estado_t : 4-bit state encoding (values appear on db_estado)
//   - SEL_*    : character index driven on sel_letra
//   - default cycle counts for the timeout and continuous-mode interval
package trena_pkg;

  typedef enum logic [3:0] {
    ST_OCIOSO         = 4'h0,
    ST_DISPARA        = 4'h1,
    ST_AGUARDA_MEDIDA = 4'h2,
    ST_TRANSMITE      = 4'h3,
    ST_AGUARDA_TX     = 4'h4,
    ST_PROXIMO        = 4'h5,
    ST_FINAL          = 4'h6,
    ST_INTERVALO      = 4'h7,
    ST_ERRO           = 4'hE
  } estado_t;

  localparam logic [1:0] SEL_CENTENA    = 2'd0;
  localparam logic [1:0] SEL_DEZENA     = 2'd1;
  localparam logic [1:0] SEL_UNIDADE    = 2'd2;
  localparam logic [1:0] SEL_TERMINADOR = 2'd3;

  localparam int CICLOS_TIMEOUT_PADRAO   = 2_500_000;
  localparam int CICLOS_INTERVALO_PADRAO = 25_000_000;

  // Width needed to count 0..m-1 (at least one bit).
  function automatic int largura_contador(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/trena_uc_contador_timeout.sv
// contador_timeout: modulo-M up counter.
//   clock, reset : clock and asynchronous active-high reset
//   clr          : synchronous clear, wins over en
//   en           : count one step per cycle
//   tc           : high while the count equals M-1
module contador_timeout
  import trena_pkg::*;
#(
  parameter int M = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = largura_contador(M);
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, wrap at the terminal value, or step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == ULTIMO) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == ULTIMO);

endmodule

// File: rtl/trena_uc.sv
// trena_uc: control unit that sequences the trena datapath.
//   Requests a measurement (mensurar), waits for pronto_medida with a
//   timeout, then sends hundreds/tens/units/'#' one character at a time
//   (partida_serial + sel_letra, each acknowledged by pronto_serial).
//   Optional continuous mode repeats the measurement after an interval.
// Ports:
//   clock, reset        : 50 MHz clock, asynchronous active-high reset
//   medir               : single-cycle request, honoured only when idle
//   modo_continuo       : level, 1 = repeat automatically
//   pronto_medida       : datapath pulse, distance valid
//   pronto_serial       : datapath pulse, character sent
//   mensurar            : one-cycle pulse starting the sensor measurement
//   partida_serial      : one-cycle pulse starting one character
//   sel_letra           : character index (0 hundreds .. 3 '#')
//   pronto              : one-cycle pulse after '#' is sent
//   timeout             : one-cycle pulse when the measurement times out
//   db_estado           : current state code
module trena_uc
  import trena_pkg::*;
#(
  parameter int CICLOS_TIMEOUT   = CICLOS_TIMEOUT_PADRAO,
  parameter int CICLOS_INTERVALO = CICLOS_INTERVALO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       modo_continuo,
  input  logic       pronto_medida,
  input  logic       pronto_serial,
  output logic       mensurar,
  output logic       partida_serial,
  output logic [1:0] sel_letra,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t    estado_q, estado_d;
  logic [1:0] letra_q, letra_d;

  // Pulse outputs are registered from the next-state decode so that they
  // line up exactly with the cycle spent in the corresponding state.
  logic mensurar_q, mensurar_d;
  logic partida_q, partida_d;
  logic pronto_q, pronto_d;
  logic timeout_q, timeout_d;

  logic to_en, to_tc;
  logic iv_en, iv_tc;

  // Each timer only runs in its own waiting state and is held at 0 otherwise.
  assign to_en = (estado_q == ST_AGUARDA_MEDIDA);
  assign iv_en = (estado_q == ST_INTERVALO);

  contador_timeout #(.M(CICLOS_TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (~to_en),
    .en    (to_en),
    .tc    (to_tc)
  );

  contador_timeout #(.M(CICLOS_INTERVALO)) u_intervalo (
    .clock (clock),
    .reset (reset),
    .clr   (~iv_en),
    .en    (iv_en),
    .tc    (iv_tc)
  );

  // Next state and character counter.
  always_comb begin
    estado_d = estado_q;
    letra_d  = letra_q;
    case (estado_q)
      ST_OCIOSO: begin
        if (medir || modo_continuo) begin
          estado_d = ST_DISPARA;
          letra_d  = SEL_CENTENA;
        end else begin
          estado_d = ST_OCIOSO;
        end
      end
      ST_DISPARA: begin
        estado_d = ST_AGUARDA_MEDIDA;
      end
      ST_AGUARDA_MEDIDA: begin
        // A distance arriving on the terminal cycle still counts.
        if (pronto_medida) begin
          estado_d = ST_TRANSMITE;
        end else if (to_tc) begin
          estado_d = ST_ERRO;
        end else begin
          estado_d = ST_AGUARDA_MEDIDA;
        end
      end
      ST_TRANSMITE: begin
        estado_d = ST_AGUARDA_TX;
      end
      ST_AGUARDA_TX: begin
        if (pronto_serial) begin
          if (letra_q == SEL_TERMINADOR) begin
            estado_d = ST_FINAL;
          end else begin
            estado_d = ST_PROXIMO;
          end
        end else begin
          estado_d = ST_AGUARDA_TX;
        end
      end
      ST_PROXIMO: begin
        // Only reached with letra_q < 3, so this never wraps.
        letra_d  = letra_q + 2'd1;
        estado_d = ST_TRANSMITE;
      end
      ST_FINAL, ST_ERRO: begin
        if (modo_continuo) begin
          estado_d = ST_INTERVALO;
        end else begin
          estado_d = ST_OCIOSO;
        end
      end
      ST_INTERVALO: begin
        if (!modo_continuo) begin
          estado_d = ST_OCIOSO;
        end else if (iv_tc) begin
          estado_d = ST_DISPARA;
          letra_d  = SEL_CENTENA;
        end else begin
          estado_d = ST_INTERVALO;
        end
      end
      default: begin
        estado_d = ST_OCIOSO;
      end
    endcase
  end

  // Moore output decode of the state about to be entered.
  always_comb begin
    mensurar_d = (estado_d == ST_DISPARA);
    partida_d  = (estado_d == ST_TRANSMITE);
    pronto_d   = (estado_d == ST_FINAL);
    timeout_d  = (estado_d == ST_ERRO);
  end

  // State, character counter and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_OCIOSO;
      letra_q    <= SEL_CENTENA;
      mensurar_q <= 1'b0;
      partida_q  <= 1'b0;
      pronto_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      letra_q    <= letra_d;
      mensurar_q <= mensurar_d;
      partida_q  <= partida_d;
      pronto_q   <= pronto_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mensurar       = mensurar_q;
  assign partida_serial = partida_q;
  assign pronto         = pronto_q;
  assign timeout        = timeout_q;
  assign sel_letra      = letra_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_trena_uc.sv
// Directed self-checking bench for trena_uc with short timer parameters.
module tb_trena_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       medir;
  logic       modo_continuo;
  logic       pronto_medida;
  logic       pronto_serial;
  logic       mensurar;
  logic       partida_serial;
  logic [1:0] sel_letra;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;
  int n_mens = 0;
  int n_part = 0;
  int n_to   = 0;

  always #5 clock = ~clock;

  trena_uc #(.CICLOS_TIMEOUT(100), .CICLOS_INTERVALO(50)) dut (
    .clock          (clock),
    .reset          (reset),
    .medir          (medir),
    .modo_continuo  (modo_continuo),
    .pronto_medida  (pronto_medida),
    .pronto_serial  (pronto_serial),
    .mensurar       (mensurar),
    .partida_serial (partida_serial),
    .sel_letra      (sel_letra),
    .pronto         (pronto),
    .timeout        (timeout),
    .db_estado      (db_estado)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clock) begin
    if (mensurar)       n_mens++;
    if (partida_serial) n_part++;
    if (timeout)        n_to++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // medir pulse; mensurar must be high exactly in the following cycle.
  task automatic start_meas();
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("mensurar_on", {31'd0, mensurar}, 32'd1);
    chk("st_dispara", {28'd0, db_estado}, 32'd1);
    tick();
    chk("mensurar_off", {31'd0, mensurar}, 32'd0);
    chk("st_aguarda", {28'd0, db_estado}, 32'd2);
  endtask

  // pronto_medida pulse after 'espera' cycles; lands in transmite.
  task automatic give_medida(input int espera);
    repeat (espera) tick();
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    chk("st_transmite", {28'd0, db_estado}, 32'd3);
  endtask

  // Serves the four characters, answering 10 cycles after each partida.
  // Returns early in aguarda_tx of character stop_at.
  task automatic do_chars(input int stop_at, input bit busy);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("partida%0d", i), {31'd0, partida_serial}, 32'd1);
      chk($sformatf("sel%0d", i), {30'd0, sel_letra}, i);
      tick();
      chk($sformatf("aguarda_tx%0d", i), {28'd0, db_estado}, 32'd4);
      if (i == stop_at) return;
      repeat (4) tick();
      if (busy) begin
        medir = 1'b1;
        tick();
        medir = 1'b0;
      end else begin
        tick();
      end
      repeat (4) tick();
      chk($sformatf("sel_stable%0d", i), {30'd0, sel_letra}, i);
      pronto_serial = 1'b1;
      tick();
      pronto_serial = 1'b0;
      if (i < 3) begin
        chk($sformatf("proximo%0d", i), {28'd0, db_estado}, 32'd5);
        tick();
      end else begin
        chk("st_final", {28'd0, db_estado}, 32'd6);
        chk("pronto_on", {31'd0, pronto}, 32'd1);
      end
    end
  endtask

  int m0, p0, t0;

  initial begin
    reset = 1'b1;
    medir = 1'b0;
    modo_continuo = 1'b0;
    pronto_medida = 1'b0;
    pronto_serial = 1'b0;
    repeat (2) tick();
    chk("rst_estado", {28'd0, db_estado}, 32'd0);
    chk("rst_outs", {26'd0, mensurar, partida_serial, sel_letra, pronto, timeout}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_stay", {28'd0, db_estado}, 32'd0);

    // Single measurement.
    m0 = n_mens; p0 = n_part;
    start_meas();
    give_medida(19);
    do_chars(4, 1'b0);
    tick();
    chk("back_idle", {28'd0, db_estado}, 32'd0);
    chk("pronto_off", {31'd0, pronto}, 32'd0);
    chk("single_mens_cnt", n_mens - m0, 32'd1);
    chk("single_part_cnt", n_part - p0, 32'd4);

    // Timeout: no pronto_medida.
    p0 = n_part;
    start_meas();
    repeat (99) tick();
    chk("to_not_yet", {28'd0, db_estado}, 32'd2);
    chk("to_not_yet_pulse", {31'd0, timeout}, 32'd0);
    tick();
    chk("st_erro", {28'd0, db_estado}, 32'd14);
    chk("timeout_on", {31'd0, timeout}, 32'd1);
    tick();
    chk("erro_idle", {28'd0, db_estado}, 32'd0);
    chk("timeout_off", {31'd0, timeout}, 32'd0);
    chk("to_no_partida", n_part - p0, 32'd0);

    // Priority: pronto_medida on the terminal cycle.
    t0 = n_to;
    start_meas();
    give_medida(99);
    chk("prio_no_timeout", {31'd0, timeout}, 32'd0);
    do_chars(4, 1'b0);
    tick();
    chk("prio_idle", {28'd0, db_estado}, 32'd0);
    chk("prio_to_cnt", n_to - t0, 32'd0);

    // Busy/ignore: spurious pronto_serial while waiting, medir during aguarda_tx.
    m0 = n_mens; p0 = n_part;
    start_meas();
    repeat (3) tick();
    pronto_serial = 1'b1;
    tick();
    pronto_serial = 1'b0;
    chk("spurious_ignored", {28'd0, db_estado}, 32'd2);
    give_medida(5);
    do_chars(4, 1'b1);
    tick();
    chk("busy_idle", {28'd0, db_estado}, 32'd0);
    chk("busy_mens_cnt", n_mens - m0, 32'd1);
    chk("busy_part_cnt", n_part - p0, 32'd4);

    // Continuous mode.
    modo_continuo = 1'b1;
    tick();
    chk("cont_mensurar", {31'd0, mensurar}, 32'd1);
    tick();
    chk("cont_aguarda", {28'd0, db_estado}, 32'd2);
    give_medida(5);
    do_chars(4, 1'b0);
    tick();
    chk("st_intervalo", {28'd0, db_estado}, 32'd7);
    // 50 intervalo cycles, then dispara.
    repeat (49) tick();
    chk("iv_not_yet", {28'd0, db_estado}, 32'd7);
    chk("iv_no_mens", {31'd0, mensurar}, 32'd0);
    tick();
    chk("iv_dispara", {28'd0, db_estado}, 32'd1);
    chk("iv_mensurar", {31'd0, mensurar}, 32'd1);
    chk("iv_sel_clear", {30'd0, sel_letra}, 32'd0);
    tick();
    give_medida(3);
    do_chars(4, 1'b0);
    tick();
    chk("st_intervalo2", {28'd0, db_estado}, 32'd7);
    repeat (10) tick();
    modo_continuo = 1'b0;
    tick();
    chk("cont_drop_idle", {28'd0, db_estado}, 32'd0);
    m0 = n_mens;
    repeat (60) tick();
    chk("cont_drop_no_mens", n_mens - m0, 32'd0);
    chk("cont_drop_stay", {28'd0, db_estado}, 32'd0);

    // Asynchronous reset during aguarda_tx of the units character.
    start_meas();
    give_medida(2);
    do_chars(2, 1'b0);
    chk("pre_rst_sel", {30'd0, sel_letra}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_estado", {28'd0, db_estado}, 32'd0);
    chk("arst_outs", {26'd0, mensurar, partida_serial, sel_letra, pronto, timeout}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    p0 = n_part;
    start_meas();
    give_medida(4);
    do_chars(4, 1'b0);
    tick();
    chk("post_rst_idle", {28'd0, db_estado}, 32'd0);
    chk("post_rst_part_cnt", n_part - p0, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trena_uc.md
Name: trena_uc

Overview:
- Control unit for the ultrasonic tape-measure; sits directly beside the trena datapath and sequences it.
- Issues the measurement request, waits for the distance, then serially sends four characters.
- The four characters are hundreds, tens, units and the '#' terminator, each selected via sel_letra and handshaked with pronto_serial.
- Adds a measurement timeout and an optional continuous (periodic) mode.

Parameters:
- CICLOS_TIMEOUT, 2_500_000, max cycles to wait for pronto_medida (50 ms at 50 MHz).
- CICLOS_INTERVALO, 25_000_000, idle cycles between measurements in continuous mode (500 ms).

Ports:
- clock  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high; forces state ocioso
- medir  input  1  single-cycle measurement request, already synchronized/debounced
- modo_continuo  input  1  level; 1 = repeat measurements automatically
- pronto_medida  input  1  pulse from the datapath: distance valid
- pronto_serial  input  1  pulse from the datapath: current character transmitted
- mensurar  output  1  one-cycle pulse that starts the HC-SR04 measurement
- partida_serial  output  1  one-cycle pulse that starts one character transmission
- sel_letra  output  2  character select: 0 hundreds, 1 tens, 2 units, 3 '#'
- pronto  output  1  one-cycle pulse after the '#' is transmitted
- timeout  output  1  one-cycle pulse when a measurement times out
- db_estado  output  4  current state code, for debug display

Behaviour:
- Moore machine; all outputs are decoded from the registered state and the registered character counter.
- States and codes:
  - ocioso 0
  - dispara 1
  - aguarda_medida 2
  - transmite 3
  - aguarda_tx 4
  - proximo 5
  - final 6
  - intervalo 7
  - erro 0xE
- Reset (asynchronous):
  - State goes to ocioso; char counter and both timers clear.
  - All outputs are 0 and sel_letra = 0.
  - Reset mid-operation aborts any measurement or transmission immediately.
- ocioso:
  - medir = 1 or modo_continuo = 1 → dispara, with char counter cleared.
  - Otherwise stay.
  - Latency: medir sampled high at edge N puts mensurar high during cycle N+1.
- dispara: mensurar = 1 for exactly one cycle; clear the timeout timer; → aguarda_medida.
- aguarda_medida:
  - The timeout timer increments every cycle.
  - pronto_medida = 1 → transmite. This takes priority even if the timer hits its terminal count in the same cycle.
  - Timer reaches CICLOS_TIMEOUT-1 with no pronto_medida → erro.
- transmite: partida_serial = 1 for one cycle; → aguarda_tx.
- aguarda_tx: wait for pronto_serial. Then → final if counter = 3, else → proximo.
- proximo: increment the char counter (2 bits, never wraps here); → transmite.
- sel_letra always equals the char counter and is stable throughout transmite/aguarda_tx.
- final: pronto = 1 for one cycle.
  - → intervalo if modo_continuo = 1, else → ocioso.
- erro: timeout = 1 for one cycle; no characters are sent.
  - → intervalo if modo_continuo = 1, else → ocioso.
- intervalo:
  - The interval timer increments every cycle.
  - modo_continuo drops to 0 → ocioso, checked with priority.
  - Timer reaches CICLOS_INTERVALO-1 → dispara, clearing the counter.
- Ignored inputs:
  - medir is ignored in every state except ocioso; no queuing.
  - pronto_medida outside aguarda_medida is ignored.
  - pronto_serial outside aguarda_tx is ignored.
- Unused state codes → ocioso on the next clock.
- Timer widths: $clog2 of the respective parameter. Each timer holds at 0 whenever it is not in its counting state.

Decomposition:
- Shared package trena_pkg holds:
  - the state encoding constants (4-bit);
  - the character index constants SEL_CENTENA=0, SEL_DEZENA=1, SEL_UNIDADE=2, SEL_TERMINADOR=3.
- One sub-module, contador_timeout:
  - parameterized modulo-M counter with synchronous clear, enable, and terminal-count output;
  - instantiated twice, once for the timeout timer and once for the interval timer.

Test Plan:
- Sim parameters: CICLOS_TIMEOUT=100, CICLOS_INTERVALO=50.
- Single measurement: medir pulse; pronto_medida at +20 cycles; pronto_serial 10 cycles after each partida.
  → mensurar exactly one pulse, one cycle after medir.
  → four partida_serial pulses with sel_letra 0,1,2,3.
  → pronto pulse after the 4th pronto_serial; back to db_estado = 0.
- Timeout: medir, no pronto_medida.
  → timeout pulse 100 cycles after aguarda_medida is entered.
  → no partida_serial; state returns to 0.
- Priority: pronto_medida asserted on the timer's terminal cycle.
  → transmite is entered; no timeout pulse.
- Continuous mode: modo_continuo = 1 with prompt responses.
  → a new mensurar 50 cycles after each final.
  → dropping modo_continuo during intervalo returns to ocioso without a further mensurar.
- Busy/ignore: medir pulses during aguarda_tx, plus a spurious pronto_serial during aguarda_medida.
  → no extra mensurar or partida; sel_letra sequence unchanged.
- Asynchronous reset: assert during aguarda_tx with sel_letra = 2.
  → outputs 0 and db_estado = 0 immediately, without waiting for a clock edge.
  → the next medir restarts at sel_letra = 0.
